// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU step monitor: default parameters,
// step FSM encoding and the special display selector codes.
package cpu_dbg_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_NUM_CH     = 2;
  localparam int DEF_DEB_CYCLES = 20000;
  localparam int DEF_RUN_DIV    = 50000000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE    = 2'd1,
    ST_WAIT_REL = 2'd2
  } step_state_e;

  // Selector code that shows the captured flags.
  function automatic int sel_flags_code(input int nbytes);
    return nbytes;
  endfunction

  // Selector code that shows the low byte of the step counter.
  function automatic int sel_count_code(input int nbytes);
    return nbytes + 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter for a raw pushbutton.
// The accepted level resets to "pressed" so that a button already held when
// reset is released is never mistaken for a fresh press.
module btn_debounce
  import cpu_dbg_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser, counter and accepted level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/cpu_step_monitor.sv
// Debug front-end for a soft CPU: issues single-step or free-running
// clock-enable pulses, counts them, snapshots the CPU results after each
// step and shows a selectable byte of that snapshot on the LEDs.
module cpu_step_monitor
  import cpu_dbg_pkg::*;
#(
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int NUM_CH     = DEF_NUM_CH,
  parameter  int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter  int RUN_DIV    = DEF_RUN_DIV,
  localparam int NBYTES     = NUM_CH * DATA_W / 8,
  localparam int SEL_W      = $clog2(NBYTES + 2)
) (
  input  logic                     clka,
  input  logic                     rsta,
  input  logic                     step_btn,
  input  logic                     run_mode,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     zfa,
  input  logic                     ofa,
  input  logic [SEL_W-1:0]         sela,
  output logic                     cpu_step,
  output logic [15:0]              step_cnt,
  output logic [7:0]               LED
);

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam int TBL_N = 2 ** SEL_W;

  logic                     deb_level;
  step_state_e              state_q, state_d;
  logic                     deb_prev_q;
  logic                     mode_q;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [15:0]              cnt_q, cnt_d;
  logic                     snap_q;
  logic [NUM_CH*DATA_W-1:0] hold_q, hold_d;
  logic                     zf_hold_q, zf_hold_d;
  logic                     of_hold_q, of_hold_d;
  logic [7:0]               led_q, led_d;
  logic                     mode_chg, rise, step_now;
  logic [7:0]               byte_tbl [TBL_N];

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk    (clka),
    .rst_n  (rsta),
    .btn_raw(step_btn),
    .level  (deb_level)
  );

  assign mode_chg = (run_mode != mode_q);
  assign rise     = deb_level & ~deb_prev_q;
  // A step comes either from the single-step FSM or the free-run divider.
  assign step_now = (state_q == ST_PULSE) | (mode_q & (div_q == DIV_LAST));

  // Step FSM and free-run divider; a mode change parks both for one cycle.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    if (mode_chg) begin
      state_d = ST_IDLE;
    end else if (mode_q) begin
      state_d = ST_IDLE;
      div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:     if (rise) state_d = ST_PULSE;
        ST_PULSE:    state_d = ST_WAIT_REL;
        ST_WAIT_REL: if (!deb_level) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Step counter and result snapshot taken the cycle after each step.
  always_comb begin
    cnt_d     = cnt_q + 16'(step_now);
    hold_d    = hold_q;
    zf_hold_d = zf_hold_q;
    of_hold_d = of_hold_q;
    if (snap_q) begin
      hold_d    = ch_data;
      zf_hold_d = zfa;
      of_hold_d = ofa;
    end
  end

  // Every selector code maps to a byte; unused codes read as zero.
  generate
    for (genvar gi = 0; gi < TBL_N; gi++) begin : g_tbl
      if (gi < NBYTES) begin : g_byte
        assign byte_tbl[gi] = hold_q[gi*8 +: 8];
      end else if (gi == sel_flags_code(NBYTES)) begin : g_flags
        assign byte_tbl[gi] = {6'b0, of_hold_q, zf_hold_q};
      end else if (gi == sel_count_code(NBYTES)) begin : g_count
        assign byte_tbl[gi] = cnt_q[7:0];
      end else begin : g_zero
        assign byte_tbl[gi] = 8'h00;
      end
    end
  endgenerate

  // Display byte selection.
  always_comb begin
    led_d = byte_tbl[sela];
  end

  // All monitor state registers.
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      state_q    <= ST_IDLE;
      deb_prev_q <= 1'b1;
      mode_q     <= 1'b0;
      div_q      <= '0;
      cnt_q      <= '0;
      snap_q     <= 1'b0;
      hold_q     <= '0;
      zf_hold_q  <= 1'b0;
      of_hold_q  <= 1'b0;
      led_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      deb_prev_q <= deb_level;
      mode_q     <= run_mode;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      snap_q     <= step_now;
      hold_q     <= hold_d;
      zf_hold_q  <= zf_hold_d;
      of_hold_q  <= of_hold_d;
      led_q      <= led_d;
    end
  end

  assign cpu_step = step_now;
  assign step_cnt = cnt_q;
  assign LED      = led_q;

endmodule

// File: tb/tb_cpu_step_monitor.sv
// Self-checking bench for cpu_step_monitor with a behavioural model.
module tb_cpu_step_monitor;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 2;
  localparam int DEB    = 4;
  localparam int RDIV   = 8;
  localparam int NB     = NUM_CH * DATA_W / 8;
  localparam int SW     = $clog2(NB + 2);

  logic                     clka     = 1'b0;
  logic                     rsta     = 1'b0;
  logic                     step_btn = 1'b0;
  logic                     run_mode = 1'b0;
  logic                     zfa      = 1'b0;
  logic                     ofa      = 1'b0;
  logic [NUM_CH*DATA_W-1:0] ch_data  = '0;
  logic [SW-1:0]            sela     = '0;
  logic                     cpu_step;
  logic [15:0]              step_cnt;
  logic [7:0]               LED;

  int n_cmp  = 0;
  int n_bad  = 0;
  int pulses = 0;

  always #5 clka = ~clka;

  cpu_step_monitor #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEB_CYCLES(DEB), .RUN_DIV(RDIV)
  ) dut (
    .clka(clka), .rsta(rsta), .step_btn(step_btn), .run_mode(run_mode),
    .ch_data(ch_data), .zfa(zfa), .ofa(ofa), .sela(sela),
    .cpu_step(cpu_step), .step_cnt(step_cnt), .LED(LED)
  );

  // ---------------- behavioural model (values after the latest edge) -----
  bit [1:0]  m_hist;        // raw button at the previous two edges
  bit        m_lvl, m_lvl_prev;
  int        m_streak;      // consecutive samples disagreeing with m_lvl
  bit        m_mode;
  int        m_div;
  bit        m_sp;          // single-step pulse active
  bit [63:0] m_hold;
  bit        m_zf, m_of;
  bit [15:0] m_cnt;
  bit [7:0]  m_led;
  bit        m_snap;        // a step happened in the previous cycle

  function automatic bit m_step();
    return m_sp || (m_mode && m_div == RDIV - 1);
  endfunction

  function automatic bit [7:0] led_of(input int s);
    if (s < NB) return m_hold[8*s +: 8];
    if (s == NB) return {6'b0, m_of, m_zf};
    if (s == NB + 1) return m_cnt[7:0];
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_hist = '0; m_lvl = 1'b1; m_lvl_prev = 1'b1; m_streak = 0;
    m_mode = 1'b0; m_div = 0; m_sp = 1'b0; m_hold = '0;
    m_zf = 1'b0; m_of = 1'b0; m_cnt = '0; m_led = '0; m_snap = 1'b0;
  endtask

  task automatic model_edge();
    bit step_now, samp, chg, rise, nlvl;
    step_now = m_step();
    samp     = m_hist[1];
    chg      = (run_mode != m_mode);
    rise     = m_lvl && !m_lvl_prev;
    m_led    = led_of(int'(sela));
    nlvl     = m_lvl;
    if (samp != m_lvl) begin
      m_streak++;
      if (m_streak == DEB) begin
        nlvl = !m_lvl;
        m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
    m_lvl_prev = m_lvl;
    m_lvl      = nlvl;
    m_hist     = {m_hist[0], step_btn};
    m_sp       = rise && !chg && !run_mode;
    if (chg || !run_mode) m_div = 0;
    else m_div = (m_div + 1) % RDIV;
    m_mode = run_mode;
    if (m_snap) begin
      m_hold = ch_data; m_zf = zfa; m_of = ofa;
    end
    m_snap = step_now;
    if (step_now) m_cnt++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model at the edge, compare just after it.
  task automatic tick();
    @(posedge clka);
    if (!rsta) model_reset();
    else model_edge();
    #1;
    check("cpu_step", {31'b0, cpu_step}, {31'b0, m_step()});
    check("step_cnt", {16'b0, step_cnt}, {16'b0, m_cnt});
    check("LED", {24'b0, LED}, {24'b0, m_led});
    if (cpu_step) pulses++;
  endtask

  task automatic do_reset();
    rsta = 1'b0;
    model_reset();
    repeat (2) tick();
    rsta = 1'b1;
    repeat (8) tick();
  endtask

  task automatic show_led(input int s, input logic [7:0] exp, input string name);
    sela = SW'(s);
    repeat (2) tick();
    check(name, {24'b0, LED}, {24'b0, exp});
    $display("sela=%0d LED=0x%02h", s, LED);
  endtask

  initial begin
    int hold_left;
    bit seen;
    model_reset();

    // Reset state
    repeat (3) tick();
    check("rst_cpu_step", {31'b0, cpu_step}, 32'd0);
    check("rst_step_cnt", {16'b0, step_cnt}, 32'd0);
    check("rst_LED", {24'b0, LED}, 32'd0);
    rsta = 1'b1;
    repeat (8) tick();
    $display("reset done step_cnt=%0d LED=0x%02h", step_cnt, LED);

    // Held press gives exactly one step
    pulses = 0; step_btn = 1'b1;
    repeat (20) tick();
    step_btn = 1'b0;
    repeat (10) tick();
    check("press_pulses", pulses, 32'd1);
    check("press_cnt", {16'b0, step_cnt}, 32'd1);
    $display("held press: pulses=%0d step_cnt=%0d", pulses, step_cnt);

    // Short glitch is rejected
    pulses = 0; step_btn = 1'b1;
    repeat (3) tick();
    step_btn = 1'b0;
    repeat (10) tick();
    check("glitch_pulses", pulses, 32'd0);
    check("glitch_cnt", {16'b0, step_cnt}, 32'd1);
    $display("glitch: pulses=%0d step_cnt=%0d", pulses, step_cnt);

    // Free-run for 40 cycles with a fixed result pattern
    do_reset();
    ch_data = 64'h1122334455667788; zfa = 1'b1; ofa = 1'b0;
    pulses = 0; run_mode = 1'b1;
    repeat (40) tick();
    check("freerun_pulses", pulses, 32'd5);
    run_mode = 1'b0;
    tick();
    check("freerun_cnt", {16'b0, step_cnt}, 32'd5);
    check("modechg_nopulse", {31'b0, cpu_step}, 32'd0);
    $display("free-run: pulses=%0d step_cnt=%0d", pulses, step_cnt);

    // Display mux
    show_led(0, 8'h88, "led_sel0");
    show_led(7, 8'h11, "led_sel7");
    show_led(8, 8'h01, "led_flags");
    show_led(9, 8'h05, "led_count");
    show_led(10, 8'h00, "led_sel10");
    show_led(15, 8'h00, "led_sel15");

    // Data change without a step leaves the display alone
    ch_data = 64'hDEADBEEFCAFEF00D;
    show_led(0, 8'h88, "led_nostep");

    // Reset in the middle of a pulse with the button held
    do_reset();
    step_btn = 1'b1; seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      seen = cpu_step;
    end
    check("pulse_seen", {31'b0, seen}, 32'd1);
    #2;
    rsta = 1'b0;
    model_reset();
    #1;
    check("midpulse_cpu_step", {31'b0, cpu_step}, 32'd0);
    check("midpulse_cnt", {16'b0, step_cnt}, 32'd0);
    check("midpulse_LED", {24'b0, LED}, 32'd0);
    repeat (3) tick();
    rsta = 1'b1; pulses = 0;
    repeat (30) tick();
    check("held_after_reset", pulses, 32'd0);
    step_btn = 1'b0;
    repeat (10) tick();
    step_btn = 1'b1;
    repeat (12) tick();
    step_btn = 1'b0;
    repeat (8) tick();
    check("repress_pulses", pulses, 32'd1);
    $display("reset mid-pulse: later pulses=%0d step_cnt=%0d", pulses, step_cnt);

    // Randomised traffic against the model
    do_reset();
    hold_left = 1; pulses = 0;
    for (int c = 0; c < 800; c++) begin
      ch_data = {$urandom, $urandom};
      zfa     = 1'($urandom_range(0, 1));
      ofa     = 1'($urandom_range(0, 1));
      sela    = SW'($urandom_range(0, 15));
      hold_left--;
      if (hold_left == 0) begin
        step_btn  = ~step_btn;
        hold_left = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 59) == 0) run_mode = ~run_mode;
      tick();
    end
    $display("random phase: pulses=%0d step_cnt=%0d", pulses, step_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_step_monitor.md
CPU_STEP_MONITOR -- requirements
Module: cpu_step_monitor

Interface
REQ-001 Parameter DATA_W, default 32: width of one observed CPU data channel; SHALL be a multiple of 8.
REQ-002 Parameter NUM_CH, default 2: number of observed data channels (1..4).
REQ-003 Parameter DEB_CYCLES, default 20000: cycles the step button must be stable before acceptance.
REQ-004 Parameter RUN_DIV, default 50000000: clock cycles between step pulses in free-run mode.
REQ-005 Derived constant NBYTES = NUM_CH*DATA_W/8; SEL_W = clog2(NBYTES+2).
REQ-006 Port clka, input, 1: single system clock, all logic on rising edge.
REQ-007 Port rsta, input, 1: asynchronous, active-low reset.
REQ-008 Port step_btn, input, 1: raw asynchronous step pushbutton, high = pressed.
REQ-009 Port run_mode, input, 1: 0 = single-step, 1 = free-run.
REQ-010 Port ch_data, input, NUM_CH*DATA_W: CPU result channels; channel 0 in LSBs.
REQ-011 Port zfa / ofa, input, 1 each: CPU zero and overflow flags.
REQ-012 Port sela, input, SEL_W: display selector.
REQ-013 Port cpu_step, output, 1: one-cycle clock-enable pulse to the CPU.
REQ-014 Port step_cnt, output, 16: number of issued step pulses.
REQ-015 Port LED, output, 8: registered display byte.

Function
REQ-016 step_btn SHALL pass through a 2-flop synchroniser before any use.
REQ-017 Debounce counter SHALL reset to 0 on each change of synchronised input and SHALL accept the new level only after DEB_CYCLES consecutive equal samples.
REQ-018 Step FSM states: IDLE, PULSE, WAIT_REL; single-step mode only.
REQ-019 IDLE -> PULSE on debounced rising edge; PULSE lasts exactly one cycle, drives cpu_step=1, -> WAIT_REL; WAIT_REL -> IDLE on debounced release.
REQ-020 Holding the button SHALL produce exactly one pulse; no repeat.
REQ-021 Free-run: divider counts 0..RUN_DIV-1; cpu_step=1 for one cycle when divider equals RUN_DIV-1, then wraps to 0.
REQ-022 Any change of run_mode SHALL clear the divider and return FSM to IDLE on the next cycle; no pulse in that cycle; a button held across the switch to single-step SHALL NOT step until released and pressed again.
REQ-023 step_cnt SHALL increment on every cpu_step pulse, wrapping 0xFFFF -> 0x0000.
REQ-024 Snapshot: cycle after each cpu_step pulse, ch_data, zfa, ofa SHALL be captured into hold registers; hold registers otherwise unchanged.
REQ-025 LED mux (registered, 1 cycle latency from sela or hold change): sela < NBYTES -> hold byte sela (byte 0 = ch_data[7:0]); sela = NBYTES -> {6'b0, of_hold, zf_hold}; sela = NBYTES+1 -> step_cnt[7:0]; any other value -> 8'h00.

Reset
REQ-026 rsta low SHALL immediately clear: FSM to IDLE, debounce and divider counters, synchroniser, cpu_step=0, step_cnt=0, hold registers=0, LED=8'h00.
REQ-027 Reset asserted mid-PULSE SHALL terminate the pulse in the same instant; release SHALL not generate a pulse even if step_btn is held.

Structure
REQ-028 FSM state encoding, selector special codes (NBYTES, NBYTES+1) and default parameters SHALL live in shared package cpu_dbg_pkg.
REQ-029 Debouncer SHALL be a separate sub-module btn_debounce (synchroniser + counter, param DEB_CYCLES, output level).

Verification (DEB_CYCLES=4, RUN_DIV=8, DATA_W=32, NUM_CH=2)
REQ-030 Press held 20 cycles, single-step -> exactly one cpu_step pulse, step_cnt=1.
REQ-031 Glitch high for 3 cycles -> no pulse, step_cnt=0.
REQ-032 run_mode=1 for 40 cycles -> pulses on 5 occurrences spaced 8 cycles; step_cnt=5.
REQ-033 ch_data=64'h1122334455667788 at step, sela=0 -> LED=8'h88; sela=7 -> 8'h11; sela=8 with zfa=1,ofa=0 -> 8'h01; sela=9 -> step_cnt[7:0]; sela=10 -> 8'h00.
REQ-034 ch_data changes with no step -> LED unchanged.
REQ-035 rsta low during PULSE with button held -> cpu_step drops immediately, all outputs 0, no pulse after release until a new press.
